// File: rtl/io_pkg.sv
// Shared address-map offsets, flag-field layout and per-channel CPU command type
// for the io_port_bank register block.
package io_pkg;

    typedef enum logic {
        FLAG_OVF = 1'b0,
        FLAG_UDR = 1'b1
    } flag_kind_e;

    typedef struct packed {
        logic rd;
        logic wr;
    } ch_cmd_t;

    function automatic int status_ofs(input int channels);
        return channels;
    endfunction

    function automatic int flags_ofs(input int channels);
        return channels + 1;
    endfunction

    // Overflow bits occupy the low CHANNELS bits, underrun bits the next CHANNELS.
    function automatic int flag_pos(input flag_kind_e kind, input int ch, input int channels);
        return ((kind == FLAG_UDR) ? channels : 0) + ch;
    endfunction

endpackage

// File: rtl/io_channel.sv
// One I/O channel: a one-deep input hold register and a one-deep output register,
// each with its own valid/ready handshake, plus overflow/underrun event pulses.
module io_channel
    import io_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  ch_cmd_t          cmd,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hold,
    output logic             in_full,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow_set,
    output logic             underrun_set
);

    logic in_take;
    logic in_full_nxt;
    logic out_take;
    logic wr_ok;
    logic out_valid_nxt;

    always_comb begin
        in_take     = in_valid & in_ready;
        in_full_nxt = in_full;
        if (in_take)
            in_full_nxt = 1'b1;
        else if (cmd.rd)
            in_full_nxt = 1'b0;

        // A write lands if the slot is empty or is being drained this same cycle.
        out_take      = out_valid & out_ready;
        wr_ok         = cmd.wr & (~out_valid | out_ready);
        out_valid_nxt = out_valid;
        if (wr_ok)
            out_valid_nxt = 1'b1;
        else if (out_take)
            out_valid_nxt = 1'b0;

        overflow_set = cmd.wr & ~wr_ok;
        underrun_set = cmd.rd & ~in_full;
    end

    // Ready tracks the next fill state so a full buffer is never offered again.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold      <= '0;
            in_full   <= 1'b0;
            in_ready  <= 1'b1;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (in_take)
                hold <= in_data;
            in_full  <= in_full_nxt;
            in_ready <= ~in_full_nxt;
            if (wr_ok)
                out_data <= wdata;
            out_valid <= out_valid_nxt;
        end
    end

endmodule

// File: rtl/io_port_bank.sv
// Memory-mapped bank of CHANNELS input/output ports: address decode, read mux,
// write-1-to-clear FLAGS register and the registered CPU read data.
module io_port_bank
    import io_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int ADDR_W   = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] ioIn,
    input  logic [CHANNELS-1:0]       ioInValid,
    output logic [CHANNELS-1:0]       ioInReady,
    output logic [CHANNELS*WIDTH-1:0] ioOut,
    output logic [CHANNELS-1:0]       ioOutValid,
    input  logic [CHANNELS-1:0]       ioOutReady,
    input  logic [ADDR_W-1:0]         cpuAddr,
    input  logic                      cpuRd,
    input  logic                      cpuWr,
    input  logic [WIDTH-1:0]          cpuWdata,
    output logic [WIDTH-1:0]          cpuRdata
);

    localparam int STATUS_OFS = status_ofs(CHANNELS);
    localparam int FLAGS_OFS  = flags_ofs(CHANNELS);

    logic [CHANNELS-1:0][WIDTH-1:0] in_vec;
    logic [CHANNELS-1:0][WIDTH-1:0] hold;
    logic [CHANNELS-1:0][WIDTH-1:0] out_vec;
    logic [CHANNELS-1:0]            in_full;
    logic [CHANNELS-1:0]            ovf_set;
    logic [CHANNELS-1:0]            udr_set;
    ch_cmd_t [CHANNELS-1:0]         cmd;

    logic [2*CHANNELS-1:0] flags;
    logic [2*CHANNELS-1:0] flags_set;
    logic [2*CHANNELS-1:0] flags_clr;
    logic [WIDTH-1:0]      status_word;
    logic [WIDTH-1:0]      flags_word;
    logic [WIDTH-1:0]      rd_mux;

    assign in_vec = ioIn;
    assign ioOut  = out_vec;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            cmd[i].rd = cpuRd && (cpuAddr == ADDR_W'(i));
            cmd[i].wr = cpuWr && (cpuAddr == ADDR_W'(i));
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        io_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .in_data     (in_vec[i]),
            .in_valid    (ioInValid[i]),
            .in_ready    (ioInReady[i]),
            .cmd         (cmd[i]),
            .wdata       (cpuWdata),
            .hold        (hold[i]),
            .in_full     (in_full[i]),
            .out_data    (out_vec[i]),
            .out_valid   (ioOutValid[i]),
            .out_ready   (ioOutReady[i]),
            .overflow_set(ovf_set[i]),
            .underrun_set(udr_set[i])
        );
    end

    always_comb begin
        flags_set = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            flags_set[flag_pos(FLAG_OVF, i, CHANNELS)] = ovf_set[i];
            flags_set[flag_pos(FLAG_UDR, i, CHANNELS)] = udr_set[i];
        end
        flags_clr = '0;
        if (cpuWr && (cpuAddr == ADDR_W'(FLAGS_OFS)))
            flags_clr = cpuWdata[2*CHANNELS-1:0];
    end

    // A same-cycle set beats the clear.
    always_ff @(posedge clk) begin
        if (reset)
            flags <= '0;
        else
            flags <= (flags & ~flags_clr) | flags_set;
    end

    always_comb begin
        status_word                         = '0;
        status_word[CHANNELS-1:0]           = in_full;
        status_word[2*CHANNELS-1:CHANNELS]  = ioOutValid;
        flags_word                          = '0;
        flags_word[2*CHANNELS-1:0]          = flags;

        rd_mux = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if ((cpuAddr == ADDR_W'(i)) && in_full[i])
                rd_mux = hold[i];
        end
        if (cpuAddr == ADDR_W'(STATUS_OFS))
            rd_mux = status_word;
        if (cpuAddr == ADDR_W'(FLAGS_OFS))
            rd_mux = flags_word;
    end

    always_ff @(posedge clk) begin
        if (reset)
            cpuRdata <= '0;
        else if (cpuRd)
            cpuRdata <= rd_mux;
    end

endmodule
